multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I subset datapath (PC, instruction memory, register file, ALU, data memory, write-back mux). It replaces the single-cycle combinational control unit with a state machine. The state machine steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memories that may stall, and generates every datapath enable and mux select. It also counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
WAIT_MAX, 255, max cycles any memory request waits for ready before bus error; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
instr  in  32  instruction register contents (opcode/funct3/funct7 decoded from it)
br_taken  in  1  branch comparator result from branch unit (valid in EXEC)
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
imem_req  out  1  instruction fetch request
ir_we  out  1  latch fetched word into instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  store qualifier, valid with dmem_req
mdr_we  out  1  latch load data
pc_we  out  1  update PC
pc_sel  out  1  0: PC+4, 1: PC+offset (taken branch / JAL)
reg_we  out  1  register file write enable
c1  out  1  immediate select, 0: I-type, 1: S-type
c2  out  1  ALU operand B, 0: rs2, 1: immediate
c3  out  2  write-back select, 00: ALU, 01: load data, 10: PC+4
alu_op  out  4  ALU operation
branch  out  3  branch condition to branch unit
illegal  out  1  sticky illegal-instruction flag
bus_err  out  1  sticky memory-timeout flag
instret  out  CNT_W  retired instruction count
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Outputs decode combinationally from state, instr and ready. Default value of every output is 0, and branch=BR_NONE (3'b010).
- Reset: state=FETCH, illegal=0, bus_err=0, instret=0, wait counter=0. A reset mid-instruction aborts it, and requests drop in the cycle after the reset edge.
- FETCH: imem_req=1. When imem_ready=1, ir_we=1 in the same cycle and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: register read cycle. Opcode not in {0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BR, 1101111 JAL} → illegal=1 and go to HALT. A branch with funct3 of 010 or 011 is also illegal. Any other opcode → EXEC.
- EXEC:
  - R: c2=0, next WB.
  - I-ALU/LW: c1=0, c2=1, next WB (I-ALU) or MEM (LW).
  - SW: c1=1, c2=1, alu_op=ADD, next MEM.
  - BR: branch=funct3, alu_op=SUB, pc_we=1, pc_sel=br_taken, retire, next FETCH.
  - JAL: c3=10, reg_we=1, pc_we=1, pc_sel=1, retire, next FETCH.
- MEM: dmem_req=1, dmem_we=(SW), ALU inputs held as in EXEC. The memory commits a store only on the dmem_ready cycle.
  - LW on ready: mdr_we=1, next WB.
  - SW on ready: pc_we=1, pc_sel=0, retire, next FETCH.
- WB: reg_we=1, pc_we=1, pc_sel=0, retire, next FETCH. c3=01 for LW, 00 for R/I-ALU. ALU selects are held as in EXEC.
- alu_op is the same in EXEC, MEM and WB:
  - R: {funct7[5],funct3} maps 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND. Any other funct7 → illegal.
  - I-ALU: same map with funct7[5] forced to 0, except funct3=101 uses funct7[5].
  - LW/SW/JAL: ADD.
- Cycle counts with zero-wait memory: R/I 4, LW 5, SW 4, BR 3, JAL 3.
- Timeout: the wait counter increments each FETCH/MEM cycle with ready=0 and clears on ready or state change. Reaching WAIT_MAX sets bus_err=1 and goes to HALT.
- HALT: all enables 0. Only rst exits.
- instret increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
- reg_we and dmem_we are never both 1. pc_we is 1 exactly once per retired instruction.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode constants
  - ALU_* 4-bit encodings
  - BR_NONE
  - C3_ALU/C3_MEM/C3_PC4
- One sub-module, mc_alu_dec: a combinational opcode/funct3/funct7 → alu_op + illegal decoder.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), ready tied 1 → states 0,1,2,4. reg_we=1, c3=00, alu_op=0000 in WB only. pc_we once. instret 0→1.
- LW x5,8(x1) (0x0080A283), dmem_ready low 3 cycles → MEM held 4 cycles. mdr_we on the ready cycle, then WB with c3=01. 8 cycles total.
- SW x5,12(x1) (0x0050A623) → c1=1, c2=1. dmem_req=dmem_we=1 in MEM. reg_we never 1. Retires in MEM.
- BEQ with br_taken=1, then BNE with br_taken=0 → branch=000/001. pc_sel=1/0. 3 cycles each.
- Instruction 0xFFFFFFFF → illegal=1 in the cycle after DECODE. HALT held 20 cycles with zero enables. rst clears to FETCH.
- WAIT_MAX=4 with imem_ready stuck 0 → bus_err after 4 FETCH cycles, then HALT. rst asserted mid-MEM drops dmem_req the next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the RV32I multi-cycle sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_JAL,
    CLS_BAD
  } op_cls_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] BR_NONE = 3'b010;

  localparam logic [1:0] C3_ALU = 2'b00;
  localparam logic [1:0] C3_MEM = 2'b01;
  localparam logic [1:0] C3_PC4 = 2'b10;

  function automatic op_cls_e classify(input logic [6:0] opcode);
    op_cls_e cls;
    case (opcode)
      OPC_R:   cls = CLS_R;
      OPC_I:   cls = CLS_I;
      OPC_LW:  cls = CLS_LW;
      OPC_SW:  cls = CLS_SW;
      OPC_BR:  cls = CLS_BR;
      OPC_JAL: cls = CLS_JAL;
      default: cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational decode of opcode/funct3/funct7 into instruction class,
// ALU operation and an illegal-encoding flag.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output op_cls_e    cls_o,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  function automatic logic [3:0] alu_map(input logic [3:0] key);
    logic [3:0] op;
    case (key)
      4'b0000: op = ALU_ADD;
      4'b1000: op = ALU_SUB;
      4'b0001: op = ALU_SLL;
      4'b0010: op = ALU_SLT;
      4'b0011: op = ALU_SLTU;
      4'b0100: op = ALU_XOR;
      4'b0101: op = ALU_SRL;
      4'b1101: op = ALU_SRA;
      4'b0110: op = ALU_OR;
      4'b0111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic r_funct7_ok;

  // Only SUB and SRA may carry funct7=0100000; every other nonzero funct7 is rejected.
  assign r_funct7_ok = (funct7_i == 7'b0000000) ||
                       ((funct7_i == 7'b0100000) &&
                        ((funct3_i == 3'b000) || (funct3_i == 3'b101)));

  always_comb begin
    cls_o     = classify(opcode_i);
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (cls_o)
      CLS_R: begin
        if (r_funct7_ok) alu_op_o = alu_map({funct7_i[5], funct3_i});
        else             illegal_o = 1'b1;
      end
      CLS_I: begin
        alu_op_o = alu_map({(funct3_i == 3'b101) && funct7_i[5], funct3_i});
      end
      CLS_BR: begin
        alu_op_o  = ALU_SUB;
        illegal_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
      end
      CLS_BAD: illegal_o = 1'b1;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath
// enables and selects, with retire counting, illegal and timeout flags.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             c1,
  output logic             c2,
  output logic [1:0]       c3,
  output logic [3:0]       alu_op,
  output logic [2:0]       branch,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  localparam int unsigned WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              waiting, timeout;

  op_cls_e    cls;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;
  logic [2:0] funct3;
  logic       unused_instr_fields;

  assign funct3              = instr[14:12];
  assign unused_instr_fields = ^{instr[24:15], instr[11:7]};

  mc_alu_dec u_alu_dec (
    .opcode_i  (instr[6:0]),
    .funct3_i  (funct3),
    .funct7_i  (instr[31:25]),
    .cls_o     (cls),
    .alu_op_o  (dec_alu_op),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_we    = 1'b0;
    c1        = 1'b0;
    c2        = 1'b0;
    c3        = C3_ALU;
    alu_op    = ALU_ADD;
    branch    = BR_NONE;
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    waiting   = ((state_q == ST_FETCH) && !imem_ready) ||
                ((state_q == ST_MEM) && !dmem_ready);
    timeout   = (WAIT_MAX != 0) && waiting && (wait_q == WAIT_LAST);

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op = dec_alu_op;
        case (cls)
          CLS_R:  state_d = ST_WB;
          CLS_I: begin
            c2      = 1'b1;
            state_d = ST_WB;
          end
          CLS_LW: begin
            c2      = 1'b1;
            state_d = ST_MEM;
          end
          CLS_SW: begin
            c1      = 1'b1;
            c2      = 1'b1;
            state_d = ST_MEM;
          end
          CLS_BR: begin
            branch  = funct3;
            pc_we   = 1'b1;
            pc_sel  = br_taken;
            state_d = ST_FETCH;
          end
          CLS_JAL: begin
            c3      = C3_PC4;
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            pc_sel  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        alu_op   = dec_alu_op;
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_SW);
        c1       = (cls == CLS_SW);
        c2       = 1'b1;
        if (dmem_ready) begin
          if (cls == CLS_SW) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = ST_WB;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        alu_op  = dec_alu_op;
        c2      = (cls != CLS_R);
        c3      = (cls == CLS_LW) ? C3_MEM : C3_ALU;
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Every retiring cycle is also the single PC-update cycle of that instruction.
  always_comb begin
    instret_d = pc_we ? instret_q + CNT_W'(1) : instret_q;
    if ((WAIT_MAX != 0) && waiting && (state_d == state_q)) wait_d = wait_q + WAIT_W'(1);
    else                                                     wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions
// compared cycle by cycle against a phase-list reference model.
module tb_multicycle_ctrl;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_BAD = 6;
  localparam int CW = 4;

  logic          clk, rst;
  logic [31:0]   instr;
  logic          br_taken, imem_ready, dmem_ready;
  logic          imem_req, ir_we, dmem_req, dmem_we, mdr_we, pc_we, pc_sel, reg_we, c1, c2;
  logic [1:0]    c3;
  logic [3:0]    alu_op;
  logic [2:0]    branch;
  logic          illegal, bus_err;
  logic [CW-1:0] instret;
  logic [2:0]    state_o;
  logic [20:0]   obs_vec;

  int total = 0;
  int bad   = 0;
  int exp_instret = 0;

  multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .c1(c1), .c2(c2), .c3(c3), .alu_op(alu_op), .branch(branch),
    .illegal(illegal), .bus_err(bus_err), .instret(instret), .state_o(state_o)
  );

  assign obs_vec = {state_o, imem_req, ir_we, dmem_req, dmem_we, mdr_we, pc_we,
                    pc_sel, reg_we, c1, c2, c3, alu_op, branch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LW;
      7'h23:   return K_SW;
      7'h63:   return K_BR;
      7'h6F:   return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  // The ALU encoding equals {funct7[5], funct3} for legal arithmetic ops.
  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    case (kind_of(ins))
      K_R:     return {ins[30], ins[14:12]};
      K_I:     return {(ins[14:12] == 3'd5) ? ins[30] : 1'b0, ins[14:12]};
      K_BR:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [20:0] exp_vec(input int ph, input int k, input logic [2:0] f3,
                                          input bit rdy, input bit bt, input logic [3:0] aop);
    logic imr = 1'b0, irw = 1'b0, dr = 1'b0, dw = 1'b0, mw = 1'b0;
    logic pw = 1'b0, ps = 1'b0, rw = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic [1:0] s3 = 2'b00;
    logic [3:0] op = 4'b0000;
    logic [2:0] br = 3'b010;
    case (ph)
      P_FETCH: begin imr = 1'b1; irw = rdy; end
      P_EXEC: begin
        op = aop;
        if (k == K_I || k == K_LW) s2 = 1'b1;
        if (k == K_SW) begin s1 = 1'b1; s2 = 1'b1; end
        if (k == K_BR) begin br = f3; pw = 1'b1; ps = bt; end
        if (k == K_JAL) begin s3 = 2'b10; rw = 1'b1; pw = 1'b1; ps = 1'b1; end
      end
      P_MEM: begin
        op = aop; dr = 1'b1; dw = (k == K_SW); s1 = (k == K_SW); s2 = 1'b1;
        if (rdy) begin
          if (k == K_LW) mw = 1'b1;
          else           pw = 1'b1;
        end
      end
      P_WB: begin
        op = aop; rw = 1'b1; pw = 1'b1; s2 = (k != K_R);
        s3 = (k == K_LW) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
    return {3'(ph), imr, irw, dr, dw, mw, pw, ps, rw, s1, s2, s3, op, br};
  endfunction

  // One clock cycle: drive, let outputs settle, compare, move to the next low phase.
  task automatic drive_cycle(input logic [31:0] ins, input int ph, input bit rdy, input bit bt);
    instr      = ins;
    imem_ready = (ph == P_FETCH) ? rdy : 1'($urandom_range(0, 1));
    dmem_ready = (ph == P_MEM)   ? rdy : 1'($urandom_range(0, 1));
    br_taken   = (ph == P_EXEC)  ? bt  : 1'($urandom_range(0, 1));
    #1;
    chk($sformatf("ctl ins=%08h ph%0d", ins, ph), 32'(obs_vec),
        32'(exp_vec(ph, kind_of(ins), ins[14:12], rdy, bt, ref_alu(ins))));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0; instr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_instret = 0;
    chk("reset state", 32'(state_o), 32'(P_FETCH));
    chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset instret", 32'(instret), 32'd0);
    chk("reset imem_req", 32'(imem_req), 32'd1);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input bit bt);
    int ph_q[$];
    bit rdy_q[$];
    int k = kind_of(ins);
    chk("instret", 32'(instret), 32'(exp_instret % (1 << CW)));
    for (int i = 0; i <= iw; i++) begin ph_q.push_back(P_FETCH); rdy_q.push_back(i == iw); end
    ph_q.push_back(P_DECODE); rdy_q.push_back(1'b0);
    ph_q.push_back(P_EXEC);   rdy_q.push_back(1'b0);
    if (k == K_LW || k == K_SW)
      for (int i = 0; i <= dw; i++) begin ph_q.push_back(P_MEM); rdy_q.push_back(i == dw); end
    if (k == K_R || k == K_I || k == K_LW) begin ph_q.push_back(P_WB); rdy_q.push_back(1'b0); end
    foreach (ph_q[i]) drive_cycle(ins, ph_q[i], rdy_q[i], bt);
    exp_instret++;
  endtask

  task automatic run_illegal(input logic [31:0] ins);
    drive_cycle(ins, P_FETCH, 1'b1, 1'b0);
    chk("illegal before decode", 32'(illegal), 32'd0);
    drive_cycle(ins, P_DECODE, 1'b0, 1'b0);
    chk("illegal after decode", 32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) drive_cycle(ins, P_HALT, 1'($urandom_range(0, 1)), 1'b0);
    chk("illegal sticky", 32'(illegal), 32'd1);
    chk("illegal no bus_err", 32'(bus_err), 32'd0);
    do_reset();
  endtask

  task automatic make_random(output logic [31:0] ins);
    int r_keys[10] = '{0, 8, 1, 2, 3, 4, 5, 13, 6, 7};
    int b_f3[6]    = '{0, 1, 4, 5, 6, 7};
    int key;
    int k = $urandom_range(0, 5);
    ins = $urandom;
    case (k)
      K_R: begin
        key = r_keys[$urandom_range(0, 9)];
        ins[6:0] = 7'h33; ins[14:12] = 3'(key);
        ins[31:25] = (key >= 8) ? 7'h20 : 7'h00;
      end
      K_I:  ins[6:0] = 7'h13;
      K_LW: begin ins[6:0] = 7'h03; ins[14:12] = 3'b010; end
      K_SW: begin ins[6:0] = 7'h23; ins[14:12] = 3'b010; end
      K_BR: begin ins[6:0] = 7'h63; ins[14:12] = 3'(b_f3[$urandom_range(0, 5)]); end
      default: ins[6:0] = 7'h6F;
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] ill[5] = '{32'hFFFFFFFF, 32'h022080B3, 32'h0020A063, 32'h00000000, 32'h4020C0B3};

    do_reset();

    run_instr(32'h002081B3, 0, 0, 1'b0);   // ADD
    run_instr(32'h0080A283, 0, 3, 1'b0);   // LW with three wait cycles
    run_instr(32'h0050A623, 1, 2, 1'b0);   // SW
    run_instr(32'h00208063, 0, 0, 1'b1);   // BEQ taken
    run_instr(32'h00209063, 0, 0, 1'b0);   // BNE not taken
    run_instr(32'h008000EF, 3, 0, 1'b0);   // JAL after three fetch waits
    run_instr(32'h4020D0B3, 0, 0, 1'b0);   // SRA
    run_instr(32'h4030D093, 2, 0, 1'b0);   // SRAI

    for (int n = 0; n < 40; n++) begin
      make_random(ins);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    chk("instret after random", 32'(instret), 32'(exp_instret % (1 << CW)));

    foreach (ill[i]) run_illegal(ill[i]);

    // Instruction fetch never answers: four waiting cycles, then halt.
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b0;
      #1;
      chk("timeout fetch state", 32'(state_o), 32'(P_FETCH));
      chk("timeout bus_err low", 32'(bus_err), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) drive_cycle(32'h002081B3, P_HALT, 1'($urandom_range(0, 1)), 1'b0);
    chk("timeout bus_err set", 32'(bus_err), 32'd1);
    do_reset();

    // Reset while a load waits in MEM.
    drive_cycle(32'h0080A283, P_FETCH, 1'b1, 1'b0);
    drive_cycle(32'h0080A283, P_DECODE, 1'b0, 1'b0);
    drive_cycle(32'h0080A283, P_EXEC, 1'b0, 1'b0);
    drive_cycle(32'h0080A283, P_MEM, 1'b0, 1'b0);
    rst = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("dmem_req before reset edge", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("dmem_req after reset edge", 32'(dmem_req), 32'd0);
    chk("state after mid-MEM reset", 32'(state_o), 32'(P_FETCH));
    exp_instret = 0;
    run_instr(32'h002081B3, 0, 0, 1'b0);
    chk("instret after recovery", 32'(instret), 32'(exp_instret));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
